// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial-load shift sequencer: state encoding and sizing.
package shift_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_reg_core.sv
// Bidirectional serial-in / parallel-out shift register with synchronous clear.
module shift_reg_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data
);

  // dir=1 feeds the MSB and moves bits toward the LSB; dir=0 the reverse
  always_ff @(posedge clk) begin
    if (!reset)      data <= '0;
    else if (clear)  data <= '0;
    else if (enable) data <= dir ? {ser_in, data[WIDTH-1:1]} : {data[WIDTH-2:0], ser_in};
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that serializes a captured word into shift_reg_core, n bits in either direction.
//   state   | meaning
//   IDLE    | waiting for start; data_out holds last result
//   CLEAR   | zero the register, load remaining-shift counter with n
//   SHIFT   | one shift per cycle until the counter reaches zero
//   DONE    | one-cycle done pulse, result held
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] word_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             ser_bit,
  output logic [WIDTH-1:0] data_out
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic             dir_q;
  logic [CNT_W-1:0] n_q;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_eff;
  logic [IDX_W-1:0] idx;
  logic             capture;
  logic             clear_en;
  logic             shift_en;

  assign n_eff   = (count == '0 || count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;
  assign capture = (state == S_IDLE) && start && !abort;

  // Right shifts feed word[0] first; left shifts feed word[n-1] first.
  assign idx = dir_q ? IDX_W'(n_q - cnt_q) : IDX_W'(cnt_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = abort ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (cnt_q <= CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    ser_bit  = (state == S_SHIFT) ? word_q[idx] : 1'b0;
    clear_en = (state == S_CLEAR) && !abort;
    shift_en = (state == S_SHIFT) && !abort && (cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_q  <= 1'b0;
      n_q    <= '0;
      word_q <= '0;
    end else if (capture) begin
      dir_q  <= dir;
      n_q    <= n_eff;
      word_q <= word_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)        cnt_q <= '0;
    else if (clear_en) cnt_q <= n_q;
    else if (shift_en) cnt_q <= cnt_q - CNT_W'(1);
  end

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_en),
    .enable (shift_en),
    .dir    (dir_q),
    .ser_in (ser_bit),
    .data   (data_out)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl with hand-computed expectations.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dir;
  logic [4:0]  count;
  logic [15:0] word_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic        ser_bit;
  logic [15:0] data_out;

  int total  = 0;
  int passed = 0;

  shift_seq_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .count    (count),
    .word_in  (word_in),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .ser_bit  (ser_bit),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and observes it until the block returns to IDLE.
  // done_cyc/busy_cyc count cycles after the start-sampling edge (CLEAR = cycle 1).
  task automatic run_op(input logic d, input logic [4:0] c, input logic [15:0] w,
                        input logic noisy,
                        output int done_cyc, output int busy_cyc, output int pulses,
                        output logic [15:0] result, output logic [15:0] ser_seq,
                        output logic clear_ser, output logic done_ser, output logic timed_out);
    int k;
    logic finished;
    done_cyc = -1; busy_cyc = 0; pulses = 0; result = '0; ser_seq = '0;
    clear_ser = 1'b0; done_ser = 1'b0; finished = 1'b0; k = 0;
    start = 1'b1; dir = d; count = c; word_in = w;
    tick;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!busy) begin finished = 1'b1; break; end
      busy_cyc++;
      if (cyc == 1) clear_ser = ser_bit;
      if (done) begin
        pulses++;
        done_ser = ser_bit;
        if (done_cyc < 0) begin done_cyc = cyc; result = data_out; end
        start = 1'b0;
      end else begin
        if (cyc >= 2 && k < 16) begin ser_seq[k] = ser_bit; k++; end
        if (noisy) begin start = 1'b1; dir = ~d; count = 5'd3; word_in = ~w; end
      end
      tick;
    end
    start = 1'b0;
    timed_out = !finished;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; count = '0; word_in = '0;
    tick; tick;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (ser_bit !== 1'b0) $display("FAIL reset_ser: got %b expected 0", ser_bit); else passed++;
    total++; if (data_out !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", data_out); else passed++;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_right_full;
    int dc, bc, pc; logic [15:0] r, s; logic cs, ds, to;
    run_op(1'b1, 5'd16, 16'hA5C3, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to) $display("FAIL right_timeout: got busy after 40 cycles expected idle"); else passed++;
    total++; if (r !== 16'hA5C3) $display("FAIL right_data: got %h expected a5c3", r); else passed++;
    total++; if (dc !== 18) $display("FAIL right_done_latency: got %0d expected 18", dc); else passed++;
    total++; if (bc !== 18) $display("FAIL right_busy_cycles: got %0d expected 18", bc); else passed++;
    total++; if (pc !== 1) $display("FAIL right_done_pulses: got %0d expected 1", pc); else passed++;
    total++; if (s !== 16'hA5C3) $display("FAIL right_ser_order: got %h expected a5c3", s); else passed++;
    total++; if (cs !== 1'b0 || ds !== 1'b0) $display("FAIL ser_outside_shift: got clear=%b done=%b expected 0/0", cs, ds); else passed++;
    tick; tick;
    total++; if (data_out !== 16'hA5C3) $display("FAIL idle_hold: got %h expected a5c3", data_out); else passed++;
    total++; if (ser_bit !== 1'b0) $display("FAIL idle_ser: got %b expected 0", ser_bit); else passed++;
  endtask

  task automatic test_left_then_right;
    int dc, bc, pc; logic [15:0] r, s; logic cs, ds, to;
    run_op(1'b0, 5'd16, 16'h1234, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'h1234) $display("FAIL left_data: got %h expected 1234", r); else passed++;
    total++; if (s !== 16'h2C48) $display("FAIL left_ser_order: got %h expected 2c48", s); else passed++;
    run_op(1'b1, 5'd4, 16'h000A, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'hA000) $display("FAIL right4_data: got %h expected a000", r); else passed++;
    total++; if (dc !== 6) $display("FAIL right4_latency: got %0d expected 6", dc); else passed++;
    total++; if (s !== 16'h000A) $display("FAIL right4_ser_order: got %h expected 000a", s); else passed++;
    run_op(1'b1, 5'd1, 16'h0001, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'h8000 || dc !== 3) $display("FAIL right1: got data=%h lat=%0d expected 8000/3", r, dc); else passed++;
    run_op(1'b0, 5'd1, 16'h0003, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'h0001) $display("FAIL left1_data: got %h expected 0001", r); else passed++;
    run_op(1'b0, 5'd20, 16'h8001, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'h8001 || bc !== 18) $display("FAIL count_over: got data=%h busy=%0d expected 8001/18", r, bc); else passed++;
  endtask

  task automatic test_count_zero;
    int dc, bc, pc; logic [15:0] r, s; logic cs, ds, to;
    run_op(1'b0, 5'd0, 16'hFFFF, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'hFFFF) $display("FAIL zero_data: got %h expected ffff", r); else passed++;
    total++; if (bc !== 18 || dc !== 18) $display("FAIL zero_busy: got busy=%0d lat=%0d expected 18/18", bc, dc); else passed++;
  endtask

  task automatic test_abort;
    int seen_done;
    start = 1'b1; dir = 1'b1; count = 5'd16; word_in = 16'hFFFF;
    tick;
    start = 1'b0;
    repeat (6) tick;
    total++; if (data_out !== 16'hF800) $display("FAIL abort_pre: got %h expected f800", data_out); else passed++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: got busy=%b done=%b expected 0/0", busy, done); else passed++;
    total++; if (data_out !== 16'hF800) $display("FAIL abort_hold: got %h expected f800", data_out); else passed++;
    seen_done = 0;
    repeat (3) begin if (done) seen_done++; tick; end
    total++; if (seen_done !== 0 || data_out !== 16'hF800) $display("FAIL abort_no_done: got done=%0d data=%h expected 0/f800", seen_done, data_out); else passed++;
    // abort during CLEAR: no clear, no shift
    start = 1'b1; dir = 1'b0; count = 5'd8; word_in = 16'h00FF;
    tick;
    start = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || data_out !== 16'hF800) $display("FAIL abort_clear: got busy=%b data=%h expected 0/f800", busy, data_out); else passed++;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_start_same: got busy=%b expected 0", busy); else passed++;
    // abort during DONE
    start = 1'b1; dir = 1'b1; count = 5'd1; word_in = 16'h0001;
    tick;
    start = 1'b0;
    tick; tick;
    abort = 1'b1;
    #1;
    total++; if (done !== 1'b1) $display("FAIL abort_in_done: got done=%b expected 1", done); else passed++;
    tick;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || data_out !== 16'h8000) $display("FAIL abort_done_result: got busy=%b data=%h expected 0/8000", busy, data_out); else passed++;
  endtask

  task automatic test_reset_mid_shift;
    start = 1'b1; dir = 1'b1; count = 5'd16; word_in = 16'hFFFF;
    tick;
    start = 1'b0;
    repeat (4) tick;
    total++; if (busy !== 1'b1 || data_out !== 16'hE000) $display("FAIL mid_pre: got busy=%b data=%h expected 1/e000", busy, data_out); else passed++;
    reset = 1'b0; start = 1'b1; abort = 1'b1;
    tick;
    total++; if (data_out !== 16'h0000 || busy !== 1'b0) $display("FAIL mid_reset: got data=%h busy=%b expected 0000/0", data_out, busy); else passed++;
    total++; if (done !== 1'b0 || ser_bit !== 1'b0) $display("FAIL mid_reset_outs: got done=%b ser=%b expected 0/0", done, ser_bit); else passed++;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    tick;
    total++; if (busy !== 1'b0) $display("FAIL post_reset_idle: got busy=%b expected 0", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int dc, bc, pc; logic [15:0] r, s; logic cs, ds, to;
    run_op(1'b1, 5'd16, 16'hA5C3, 1'b1, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'hA5C3) $display("FAIL busy_start_data: got %h expected a5c3", r); else passed++;
    total++; if (dc !== 18 || pc !== 1) $display("FAIL busy_start_timing: got lat=%0d pulses=%0d expected 18/1", dc, pc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got busy=%b expected 0", busy); else passed++;
    run_op(1'b0, 5'd4, 16'h000A, 1'b0, dc, bc, pc, r, s, cs, ds, to);
    total++; if (to || r !== 16'h000A || dc !== 6) $display("FAIL b2b_left4: got data=%h lat=%0d expected 000a/6", r, dc); else passed++;
  endtask

  initial begin
    test_reset;
    test_right_full;
    test_left_then_right;
    test_count_zero;
    test_abort;
    test_reset_mid_shift;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a serial load; sampled only in IDLE.
REQ-005 SHALL have port dir  input  1  1 = shift right (serial bit enters MSB), 0 = shift left (serial bit enters LSB); captured with start.
REQ-006 SHALL have port count  input  5  number of shifts n; 0 or >WIDTH treated as WIDTH; captured with start.
REQ-007 SHALL have port word_in  input  WIDTH  source word to serialize; captured with start.
REQ-008 SHALL have port abort  input  1  cancels an operation in progress.
REQ-009 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ser_bit  output  1  serial bit presented to the register this cycle.
REQ-012 SHALL have port data_out  output  WIDTH  current shift-register contents.

Function
REQ-013 SHALL implement states IDLE, CLEAR, SHIFT, DONE.
REQ-014 IDLE: start=1 SHALL capture dir, n, word_in and go to CLEAR; start=0 SHALL stay IDLE.
REQ-015 CLEAR: register SHALL be zeroed for one cycle, remaining-shift counter loaded with n, go to SHIFT.
REQ-016 SHIFT: each cycle exactly one shift in the captured direction, counter decrements; after the n-th shift go to DONE.
REQ-017 Right: bits fed word_in[0] first through word_in[n-1] last; final data_out = {word_in[n-1:0], (WIDTH-n) zeros}.
REQ-018 Left: bits fed word_in[n-1] first through word_in[0] last; final data_out = word_in[n-1:0] zero-extended.
REQ-019 DONE: done=1 for exactly one cycle, data_out held, then IDLE; start-sample to done = n+2 cycles.
REQ-020 start while busy SHALL be ignored; captured parameters SHALL not change mid-operation.
REQ-021 abort=1 in CLEAR or SHIFT SHALL return to IDLE next cycle, no done pulse, data_out holds partial value.
REQ-022 abort and start in the same IDLE cycle: abort wins, start ignored.
REQ-023 abort in DONE SHALL not suppress the done pulse.
REQ-024 In IDLE, data_out SHALL hold its last value; ser_bit SHALL be 0 outside SHIFT.
REQ-025 Counter SHALL not wrap: no shift occurs once remaining count is 0.

Reset
REQ-026 reset=0 at a rising edge SHALL force IDLE, data_out=0, done=0, busy=0, ser_bit=0, counter=0, captured parameters=0.
REQ-027 Reset SHALL take priority over start and abort in any state, including mid-SHIFT.

Structure
REQ-028 State encoding, WIDTH default and count-field width SHALL live in shared package shift_ctrl_pkg.
REQ-029 The shift datapath SHALL be one sub-module, shift_reg_core (clear, enable, direction, serial-in, parallel-out); FSM and counter stay in shift_seq_ctrl.

Verification
REQ-030 start, dir=1, count=16, word_in=16'hA5C3 -> data_out=16'hA5C3, done pulse 18 cycles after start sampled.
REQ-031 start, dir=0, count=16, word_in=16'h1234 -> data_out=16'h1234; then dir=1, count=4, word_in=16'h000A -> data_out=16'hA000.
REQ-032 dir=0, count=0, word_in=16'hFFFF -> treated as 16, data_out=16'hFFFF, busy 18 cycles.
REQ-033 abort after 5 shifts of dir=1, word_in=16'hFFFF -> data_out=16'hF800, no done, IDLE next cycle.
REQ-034 reset low during SHIFT -> next edge data_out=16'h0000, busy=0; start pulsed while busy -> ignored, result unchanged.
